// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
//
// Purpose : Shared types and constants for the system-ID checker: the FSM
//           state encoding, the Avalon-MM word addresses of the two sysid
//           registers, the width of the per-read cycle counter and small
//           helpers that classify states.
//
// Contents: state_t           - FSM state enum
//           ADDR_ID / ADDR_TS - slave word addresses (ID at 0, timestamp at 1)
//           CNT_W             - width of the per-read timeout counter
//           is_req_state()    - state issues a read command
//           is_wait_state()   - state waits for readdatavalid
//           is_read_state()   - state belongs to a read transaction
//           is_ts_state()     - state belongs to the timestamp read
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ID_REQ  = 3'd1,
        ST_RD_ID_WAIT = 3'd2,
        ST_RD_TS_REQ  = 3'd3,
        ST_RD_TS_WAIT = 3'd4,
        ST_CHECK      = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int CNT_W = 16;

    function automatic logic is_req_state(input state_t s);
        return (s == ST_RD_ID_REQ) || (s == ST_RD_TS_REQ);
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_RD_ID_WAIT) || (s == ST_RD_TS_WAIT);
    endfunction

    function automatic logic is_read_state(input state_t s);
        return is_req_state(s) || is_wait_state(s);
    endfunction

    function automatic logic is_ts_state(input state_t s);
        return (s == ST_RD_TS_REQ) || (s == ST_RD_TS_WAIT);
    endfunction

endpackage

// File: rtl/sysid_checker_timer.sv
// -----------------------------------------------------------------------------
// sysid_checker_timer
//
// Purpose : Per-read cycle counter used to bound each Avalon-MM read
//           transaction. The counter is cleared when the FSM enters a request
//           state and counts every clock the FSM spends in a read state.
//
// Ports   : clock   - rising-edge clock
//           reset   - synchronous active-high reset, counter returns to 0
//           clear   - load 0 on the next edge (has priority over enable)
//           enable  - count this clock
//           limit   - number of clocks allowed for one read (1..65535)
//           expired - high during the clock whose edge brings the counter
//                     to 'limit'; the FSM abandons the read on that edge
// -----------------------------------------------------------------------------
module sysid_checker_timer
    import sysid_checker_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;

    // One extra bit so a limit of 65535 still compares correctly when the
    // incremented value would otherwise wrap.
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};

    // Combinational expiry lets the FSM leave on the same edge the counter
    // reaches the limit, so a read occupies at most 'limit' clocks.
    assign expired = enable && (w_count_inc == {1'b0, limit});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//
// Purpose : Reads the system-ID (word 0) and build timestamp (word 1) from an
//           Avalon-MM sysid slave after reset, compares them with the values
//           this image was built for and reports the outcome as sticky flags.
//           A check runs automatically after reset and can be repeated with a
//           start pulse once the previous check is done.
//
// Build option: define SYSID_CHECKER_TS_CHECK_EN to include the timestamp
//           word in the comparison. Without it the timestamp is still read
//           and captured into ts_value but does not influence id_ok/mismatch.
//
// Parameters: EXPECTED_ID    - required value of slave word 0
//             EXPECTED_TS    - required value of slave word 1
//             TIMEOUT_CYCLES - clocks allowed per read transaction (1..65535)
//
// Ports   : clock         - rising-edge clock
//           reset         - synchronous active-high reset
//           start         - single-cycle pulse, re-run a check from DONE
//           address       - master word address (0 = ID, 1 = timestamp)
//           read          - master read request
//           waitrequest   - slave stall
//           readdatavalid - qualifies readdata
//           readdata      - slave read data
//           busy          - check in progress
//           done          - level, high from completion until the next start
//           id_ok         - with done: all compared words matched
//           mismatch      - with done: a compared word differed
//           timeout       - with done: a read exceeded TIMEOUT_CYCLES
//           id_value      - captured word 0
//           ts_value      - captured word 1
// -----------------------------------------------------------------------------
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5AE7_FD82,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

`ifdef SYSID_CHECKER_TS_CHECK_EN
    localparam bit TS_CHECK_EN = 1'b1;
`else
    localparam bit TS_CHECK_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_mismatch;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    state_t      w_state_next;
    logic        w_accept;
    logic        w_capture;
    logic        w_expired;
    logic        w_timeout_hit;
    logic        w_timer_clear;
    logic        w_timer_enable;
    logic        w_id_match;
    logic        w_ts_match;
    logic        w_words_match;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // r_read is high exactly in the request states, so this is the Avalon
    // command acceptance for the current read.
    assign w_accept  = r_read && !waitrequest;

    // Data is only taken while waiting for it; a stray readdatavalid in any
    // other state has no effect.
    assign w_capture = is_wait_state(r_state) && readdatavalid;

    // A capture on the very clock the counter expires still wins: the data
    // arrived within the allowed window.
    assign w_timeout_hit = w_expired && !w_capture;

    // -------------------------------------------------------------------------
    // Per-read timeout counter
    // -------------------------------------------------------------------------
    assign w_timer_enable = is_read_state(r_state);
    assign w_timer_clear  = is_req_state(w_state_next) && (w_state_next != r_state);

    sysid_checker_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .limit   (TIMEOUT_LIMIT),
        .expired (w_expired)
    );

    // -------------------------------------------------------------------------
    // Comparison against the build-time constants
    // -------------------------------------------------------------------------
    assign w_id_match    = (r_id_value == EXPECTED_ID);
    assign w_ts_match    = (r_ts_value == EXPECTED_TS);
    assign w_words_match = w_id_match && (!TS_CHECK_EN || w_ts_match);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // Auto-run: leave IDLE on the first clock after reset releases.
            ST_IDLE: begin
                w_state_next = ST_RD_ID_REQ;
            end
            ST_RD_ID_REQ: begin
                if (w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end else if (w_accept) begin
                    w_state_next = ST_RD_ID_WAIT;
                end
            end
            ST_RD_ID_WAIT: begin
                if (w_capture) begin
                    w_state_next = ST_RD_TS_REQ;
                end else if (w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_RD_TS_REQ: begin
                if (w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end else if (w_accept) begin
                    w_state_next = ST_RD_TS_WAIT;
                end
            end
            ST_RD_TS_WAIT: begin
                if (w_capture) begin
                    w_state_next = ST_CHECK;
                end else if (w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_DONE;
            end
            // start is only honoured here; in busy states it is ignored,
            // which also means a timeout coinciding with start is kept.
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RD_ID_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state, bus outputs and result flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_read     <= 1'b0;
            r_address  <= ADDR_ID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_state   <= w_state_next;

            // Bus outputs are registered from the next state so read and
            // address are glitch-free and stay stable through waitrequest.
            r_read    <= is_req_state(w_state_next);
            r_address <= is_ts_state(w_state_next) ? ADDR_TS : ADDR_ID;
            r_busy    <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);

            if (w_capture && (r_state == ST_RD_ID_WAIT)) begin
                r_id_value <= readdata;
            end
            if (w_capture && (r_state == ST_RD_TS_WAIT)) begin
                r_ts_value <= readdata;
            end

            if ((r_state == ST_DONE) && start) begin
                r_done     <= 1'b0;
                r_id_ok    <= 1'b0;
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b0;
            end

            if (r_state == ST_CHECK) begin
                r_done     <= 1'b1;
                r_id_ok    <= w_words_match;
                r_mismatch <= !w_words_match;
                r_timeout  <= 1'b0;
            end

            if (w_timeout_hit) begin
                r_done     <= 1'b1;
                r_id_ok    <= 1'b0;
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b1;
            end
        end
    end

    assign read     = r_read;
    assign address  = r_address;
    assign busy     = r_busy;
    assign done     = r_done;
    assign id_ok    = r_id_ok;
    assign mismatch = r_mismatch;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
//
// Directed bench for sysid_checker. A behavioural Avalon-MM slave (configurable
// data, waitrequest length, response enable and stray readdatavalid) answers
// the DUT; each scenario task drives reset/start and checks outputs against
// hand-derived values. Cycle counts are taken from the first rising edge after
// reset (or start) is released.
// -----------------------------------------------------------------------------
module tb_sysid_checker;

    localparam int TMO = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        address;
    logic        read;
    logic        waitrequest   = 1'b0;
    logic        readdatavalid = 1'b0;
    logic [31:0] readdata      = 32'h0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        mismatch;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    // slave configuration and observation
    logic [31:0] cfg_id       = 32'h0000_0000;
    logic [31:0] cfg_ts       = 32'h5AE7_FD82;
    int          cfg_wait     = 0;
    bit          cfg_respond  = 1'b1;
    bit          cfg_spurious = 1'b0;
    int          stall_violations = 0;
    int          id_req_cycles    = 0;
    int          ts_req_cycles    = 0;

    sysid_checker #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (32'h5AE7_FD82),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .address       (address),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .busy          (busy),
        .done          (done),
        .id_ok         (id_ok),
        .mismatch      (mismatch),
        .timeout       (timeout),
        .id_value      (id_value),
        .ts_value      (ts_value)
    );

    initial begin
        forever #5 clock = ~clock;
    end

    // Behavioural slave: acts 1 time unit after each falling edge, so it sees
    // reset/start changes made on that falling edge.
    initial begin : slave
        bit   pending;
        logic pend_addr;
        int   wcnt;
        logic prev_stall;
        logic prev_read;
        logic prev_addr;
        pending    = 1'b0;
        pend_addr  = 1'b0;
        wcnt       = 0;
        prev_stall = 1'b0;
        prev_read  = 1'b0;
        prev_addr  = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (prev_stall && prev_read && (read !== 1'b1 || address !== prev_addr))
                stall_violations++;
            if (read === 1'b1) begin
                if (address === 1'b1) ts_req_cycles++;
                else                  id_req_cycles++;
            end
            if (reset) begin
                pending       = 1'b0;
                wcnt          = 0;
                readdatavalid = 1'b0;
                waitrequest   = 1'b0;
                readdata      = 32'h0;
            end else if (cfg_spurious) begin
                readdatavalid = 1'b1;
                readdata      = 32'hDEAD_BEEF;
                waitrequest   = 1'b0;
            end else begin
                readdatavalid = pending;
                readdata      = pending ? (pend_addr ? cfg_ts : cfg_id) : 32'h0;
                pending       = 1'b0;
                if (read === 1'b1) begin
                    if (wcnt < cfg_wait) begin
                        waitrequest = 1'b1;
                        wcnt++;
                    end else begin
                        waitrequest = 1'b0;
                        wcnt        = 0;
                        pending     = cfg_respond;
                        pend_addr   = address;
                    end
                end else begin
                    waitrequest = 1'b0;
                    wcnt        = 0;
                end
            end
            prev_stall = waitrequest;
            prev_read  = read;
            prev_addr  = address;
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Returns the 1-based index of the rising edge after which done is seen,
    // or -1 if it never rises within max_cyc edges.
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cfg_id = 32'h0; cfg_ts = 32'h5AE7_FD82; cfg_wait = 0; cfg_respond = 1'b1;
        apply_reset();
        checks++;
        if ({read, address, busy, done, id_ok, mismatch, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000000", {read, address, busy, done, id_ok, mismatch, timeout});
        end
        checks++;
        if (id_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_id_value: got %h expected 00000000", id_value);
        end
        checks++;
        if (ts_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_ts_value: got %h expected 00000000", ts_value);
        end
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int cyc;
        cfg_id = 32'h0; cfg_ts = 32'h5AE7_FD82; cfg_wait = 0; cfg_respond = 1'b1;
        apply_reset();
        reset = 1'b0;
        wait_done(40, cyc);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected 6", cyc);
        end
        checks++;
        if ({id_ok, mismatch, timeout, busy, read} !== 5'b10000) begin
            errors++;
            $display("FAIL nominal_flags: got %b expected 10000", {id_ok, mismatch, timeout, busy, read});
        end
        checks++;
        if (ts_value !== 32'h5AE7_FD82 || id_value !== 32'h0) begin
            errors++;
            $display("FAIL nominal_values: got %h/%h expected 00000000/5ae7fd82", id_value, ts_value);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b1 || id_ok !== 1'b1) begin
            errors++;
            $display("FAIL nominal_done_held: got done=%b id_ok=%b expected 1/1", done, id_ok);
        end
        $display("test_nominal latency=%0d id=%h ts=%h", cyc, id_value, ts_value);
    endtask

    task automatic test_spurious_rdv();
        @(negedge clock);
        cfg_spurious = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (id_value !== 32'h0 || ts_value !== 32'h5AE7_FD82) begin
            errors++;
            $display("FAIL spurious_capture: got %h/%h expected 00000000/5ae7fd82", id_value, ts_value);
        end
        checks++;
        if ({done, id_ok, busy} !== 3'b110) begin
            errors++;
            $display("FAIL spurious_state: got %b expected 110", {done, id_ok, busy});
        end
        @(negedge clock);
        cfg_spurious = 1'b0;
        $display("test_spurious_rdv done");
    endtask

    task automatic test_id_mismatch();
        int cyc;
        cfg_id = 32'h0000_0001; cfg_ts = 32'h5AE7_FD82; cfg_wait = 0; cfg_respond = 1'b1;
        apply_reset();
        reset = 1'b0;
        wait_done(40, cyc);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL idmis_latency: got %0d expected 6", cyc);
        end
        checks++;
        if ({id_ok, mismatch, timeout} !== 3'b010) begin
            errors++;
            $display("FAIL idmis_flags: got %b expected 010", {id_ok, mismatch, timeout});
        end
        checks++;
        if (id_value !== 32'h0000_0001) begin
            errors++;
            $display("FAIL idmis_id_value: got %h expected 00000001", id_value);
        end
        $display("test_id_mismatch latency=%0d id=%h", cyc, id_value);
    endtask

    task automatic test_waitrequest();
        int cyc;
        cfg_id = 32'h0; cfg_ts = 32'h5AE7_FD82; cfg_wait = 3; cfg_respond = 1'b1;
        apply_reset();
        reset = 1'b0;
        stall_violations = 0;
        id_req_cycles    = 0;
        ts_req_cycles    = 0;
        wait_done(60, cyc);
        checks++;
        if (cyc !== 12) begin
            errors++;
            $display("FAIL wait_latency: got %0d expected 12", cyc);
        end
        checks++;
        if ({id_ok, mismatch, timeout} !== 3'b100) begin
            errors++;
            $display("FAIL wait_flags: got %b expected 100", {id_ok, mismatch, timeout});
        end
        checks++;
        if (stall_violations !== 0) begin
            errors++;
            $display("FAIL wait_stable: got %0d violations expected 0", stall_violations);
        end
        checks++;
        if (id_req_cycles !== 4 || ts_req_cycles !== 4) begin
            errors++;
            $display("FAIL wait_req_cycles: got %0d/%0d expected 4/4", id_req_cycles, ts_req_cycles);
        end
        cfg_wait = 0;
        $display("test_waitrequest latency=%0d", cyc);
    endtask

    // No read data ever returns; start is pulsed on the expiry clock and must
    // not disturb the recorded timeout.
    task automatic test_timeout();
        cfg_id = 32'h0; cfg_ts = 32'h5AE7_FD82; cfg_wait = 0; cfg_respond = 1'b0;
        apply_reset();
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got done=%b busy=%b expected 0/1", done, busy);
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({done, timeout, id_ok, mismatch, read, busy} !== 6'b110000) begin
            errors++;
            $display("FAIL timeout_flags: got %b expected 110000", {done, timeout, id_ok, mismatch, read, busy});
        end
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({done, timeout, busy} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_held: got %b expected 110", {done, timeout, busy});
        end
        cfg_respond = 1'b1;
        $display("test_timeout done=%b timeout=%b", done, timeout);
    endtask

    task automatic test_ts_mismatch();
        int cyc;
        cfg_id = 32'h0; cfg_ts = 32'h1234_5678; cfg_wait = 0; cfg_respond = 1'b1;
        apply_reset();
        reset = 1'b0;
        wait_done(40, cyc);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL tsmis_latency: got %0d expected 6", cyc);
        end
        checks++;
        if (ts_value !== 32'h1234_5678) begin
            errors++;
            $display("FAIL tsmis_ts_value: got %h expected 12345678", ts_value);
        end
`ifdef SYSID_CHECKER_TS_CHECK_EN
        checks++;
        if ({id_ok, mismatch, timeout} !== 3'b010) begin
            errors++;
            $display("FAIL tsmis_flags: got %b expected 010", {id_ok, mismatch, timeout});
        end
`else
        checks++;
        if ({id_ok, mismatch, timeout} !== 3'b100) begin
            errors++;
            $display("FAIL tsmis_flags: got %b expected 100", {id_ok, mismatch, timeout});
        end
`endif
        cfg_ts = 32'h5AE7_FD82;
        $display("test_ts_mismatch ts=%h id_ok=%b mismatch=%b", ts_value, id_ok, mismatch);
    endtask

    task automatic test_reset_midway();
        int cyc;
        cfg_id = 32'h0; cfg_ts = 32'h5AE7_FD82; cfg_wait = 0; cfg_respond = 1'b1;
        apply_reset();
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if ({busy, read, address} !== 3'b101) begin
            errors++;
            $display("FAIL midway_ts_wait: got %b expected 101", {busy, read, address});
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({read, address, busy, done, id_ok, mismatch, timeout} !== 7'b0 || ts_value !== 32'h0) begin
            errors++;
            $display("FAIL midway_reset: got %b ts=%h expected 0000000 ts=00000000",
                     {read, address, busy, done, id_ok, mismatch, timeout}, ts_value);
        end
        @(negedge clock);
        reset = 1'b0;
        wait_done(40, cyc);
        checks++;
        if (cyc !== 6 || id_ok !== 1'b1) begin
            errors++;
            $display("FAIL midway_autorun: got cyc=%0d id_ok=%b expected 6/1", cyc, id_ok);
        end
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({done, id_ok, mismatch, timeout, busy, read, address} !== 7'b0000110) begin
            errors++;
            $display("FAIL restart_cleared: got %b expected 0000110",
                     {done, id_ok, mismatch, timeout, busy, read, address});
        end
        @(negedge clock);
        start = 1'b0;
        wait_done(40, cyc);
        checks++;
        if (cyc !== 5 || id_ok !== 1'b1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL restart_complete: got cyc=%0d id_ok=%b mismatch=%b expected 5/1/0", cyc, id_ok, mismatch);
        end
        $display("test_reset_midway restart latency=%0d", cyc);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_spurious_rdv();
        test_id_mismatch();
        test_waitrequest();
        test_timeout();
        test_ts_mismatch();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, is the system ID value required at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 32'h5AE7_FD82, is the build timestamp required at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of clocks allowed per read transaction (range 1..65535).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clock, input, 1, is the single rising-edge clock.
REQ-006 Port reset, input, 1, is the synchronous active-high reset.
REQ-007 Port start, input, 1, is a single-cycle pulse requesting a re-check.
REQ-008 Port address, output, 1, is the Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-009 Port read, output, 1, is the Avalon-MM read request.
REQ-010 Port waitrequest, input, 1, is the slave stall.
REQ-011 Port readdatavalid, input, 1, qualifies readdata.
REQ-012 Port readdata, input, 32, is the slave read data.
REQ-013 Port busy, output, 1, is high while a check is in progress.
REQ-014 Port done, output, 1, is a level held high once a check completes, until the next check starts.
REQ-015 Port id_ok, output, 1, is high with done when all compared words matched.
REQ-016 Port mismatch, output, 1, is high with done when any compared word differed.
REQ-017 Port timeout, output, 1, is high with done when a read exceeded TIMEOUT_CYCLES.
REQ-018 Ports id_value and ts_value, output, 32 each, hold the captured words.

Function
REQ-019 The FSM SHALL have states IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, CHECK, DONE.
REQ-020 IDLE SHALL go to RD_ID_REQ on the first clock after reset deasserts (auto-run); start is not required.
REQ-021 In *_REQ states, read=1 with address stable; the command is accepted on read && !waitrequest, then the FSM goes to the matching *_WAIT state with read=0.
REQ-022 In *_WAIT states, readdata SHALL be captured into id_value/ts_value on readdatavalid; RD_ID_WAIT then goes to RD_TS_REQ, and RD_TS_WAIT goes to CHECK.
REQ-023 A per-read cycle counter (16 bits) SHALL clear on entry to each *_REQ state and increment every clock in *_REQ/*_WAIT.
REQ-024 When the counter reaches TIMEOUT_CYCLES without capture, the FSM SHALL go to DONE with timeout=1, id_ok=0, mismatch=0, read=0.
REQ-025 A readdatavalid arriving in any state other than *_WAIT SHALL be ignored.
REQ-026 CHECK SHALL compute the result in one clock: id_ok = all compared words equal; mismatch = !id_ok. It then goes to DONE.
REQ-027 done=1 and busy=0 in DONE and IDLE-after-reset (done=0); busy=1 in all other states.
REQ-028 start in DONE SHALL clear done/id_ok/mismatch/timeout and go to RD_ID_REQ next clock; start in any busy state is ignored.
REQ-029 If start and a timeout expiry coincide, the timeout SHALL be recorded; start is ignored.
REQ-030 With a zero-wait slave and readdatavalid one clock after accept, done SHALL rise exactly 6 clocks after reset deasserts.

Reset
REQ-031 Reset SHALL force state IDLE, read=0, address=0, busy=0, done=0, id_ok=0, mismatch=0, timeout=0, id_value=0, ts_value=0, counter=0.
REQ-032 Reset mid-transaction SHALL abandon the read immediately; auto-run restarts after release.

Configuration
REQ-033 Macro SYSID_CHECKER_TS_CHECK_EN defined: the timestamp word is compared against EXPECTED_TS in CHECK.
REQ-034 Macro not defined: ts_value is captured but excluded from id_ok/mismatch; the read sequence is unchanged.

Structure
REQ-035 Package sysid_checker_pkg SHALL hold the FSM state enum and the constants ADDR_ID=1'b0 and ADDR_TS=1'b1.
REQ-036 The timeout counter SHALL be a sub-module sysid_checker_timer (clear, enable, limit in; expired out).

Verification
REQ-037 Zero-wait slave returning 0 then 0x5AE7FD82 -> done=1 at 6 clocks after reset; id_ok=1, mismatch=0, timeout=0.
REQ-038 Slave returns ID 0x00000001 -> done=1, mismatch=1, id_ok=0, id_value=0x00000001.
REQ-039 waitrequest held 3 clocks on each read -> read and address stable throughout; done at 12 clocks; id_ok=1.
REQ-040 readdatavalid never asserted, TIMEOUT_CYCLES=10 -> timeout=1 and done=1 after 10 clocks in the ID read; id_ok=0.
REQ-041 Timestamp 0x12345678 -> mismatch=1 with SYSID_CHECKER_TS_CHECK_EN defined; id_ok=1 without it.
REQ-042 Reset pulsed during RD_TS_WAIT, then start pulsed in DONE -> outputs return to reset values, auto-run completes, and start reruns with flags cleared for one cycle.
